// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM write-data path.
// Occupancy encoding and skid depth used by fifo_reader.
package sdram_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int SKID_DEPTH    = 2;
  localparam int DEF_BUS_WIDTH = 16;

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry skid buffer: tail written on push, head read on pop.
// Occupancy kept as a small FSM; pointers wrap mod 2.
module skid_buf_2
  import sdram_pkg::*;
#(
  parameter int W = DEF_BUS_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output occ_e         occ,
  output logic [W-1:0] head
);

  occ_e         r_occ;
  occ_e         w_occ_nxt;
  logic [W-1:0] r_mem [SKID_DEPTH];
  logic         r_wp;
  logic         r_rp;
  logic         w_pop;
  logic         w_grow;
  logic         w_shrink;

  assign w_pop    = pop & (r_occ != EMPTY);
  assign w_grow   = push & ~w_pop;
  assign w_shrink = w_pop & ~push;
  assign occ      = r_occ;
  assign head     = r_mem[r_rp];

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= EMPTY;
    else        r_occ <= w_occ_nxt;
  end

  // Next occupancy: push+pop together holds the count
  always_comb begin
    w_occ_nxt = r_occ;
    unique case (1'b1)
      w_grow: begin
        unique case (r_occ)
          EMPTY:   w_occ_nxt = ONE;
          ONE:     w_occ_nxt = TWO;
          default: w_occ_nxt = r_occ;
        endcase
      end
      w_shrink: begin
        unique case (r_occ)
          TWO:     w_occ_nxt = ONE;
          ONE:     w_occ_nxt = EMPTY;
          default: w_occ_nxt = r_occ;
        endcase
      end
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Storage and pointer pair; cleared so head reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
    end
  end

  // Credit logic upstream must never push into a full buffer
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(r_occ == TWO && push)
  );

endmodule

// File: rtl/fifo_reader.sv
// Read-side consumer of the dual-clock fifo, valid/ready output.
// Optional popped-word counter enabled by FIFO_RD_COUNT_EN.
module fifo_reader
  import sdram_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 empty_n,
  input  logic [BUS_WIDTH-1:0] fifo_data,
  output logic                 rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

  occ_e       w_occ;
  logic       r_rd_q;
  logic       w_pop;
  logic [1:0] w_occ_est;
  logic [2:0] w_credit_use;

  if (CNT_WIDTH < 1 || BUS_WIDTH < 1) begin : g_bad_param
    $error("fifo_reader: widths must be positive");
  end

  assign w_pop     = out_valid & out_ready;
  assign out_valid = (w_occ != EMPTY);

  // Slots already spoken for: survivors after this pop plus the word in flight
  assign w_occ_est    = w_occ - 2'(w_pop);
  assign w_credit_use = {1'b0, w_occ_est} + {2'b00, r_rd_q};
  assign rd = rst_n & empty_n & (w_credit_use < 3'(SKID_DEPTH));

  // Track the pop whose data lands on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_q <= 1'b0;
    else        r_rd_q <= rd;
  end

  skid_buf_2 #(
    .W(BUS_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .push (r_rd_q),
    .pop  (w_pop),
    .din  (fifo_data),
    .occ  (w_occ),
    .head (out_data)
  );

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  assign word_cnt = r_cnt;

  // Delivered-word counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized self-checking bench for fifo_reader.
// Fifo and expected stream kept as queues in the bench.
module tb_fifo_reader;

  localparam int BW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty_n;
  logic [BW-1:0] fifo_data;
  logic          rd;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
`ifdef FIFO_RD_COUNT_EN
  logic [CW-1:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_reader #(
    .BUS_WIDTH(BW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty_n  (empty_n),
    .fifo_data(fifo_data),
    .rd       (rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef FIFO_RD_COUNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  logic [BW-1:0] q[$];
  logic [BW-1:0] expq[$];
  int            n_pop;
  int            n_deliv;
  int            n_chk;
  int            n_err;
  int            cyc;
  int            f_sz;
  bit            stall_prev;
  logic [BW-1:0] prev_data;
  int            sc_rd_n, sc_rd_first, sc_rd_last;
  int            sc_v_n, sc_v_first, sc_v_last;
  int            pat[6] = '{0, 0, 1, 0, 1, 1};

  // Behavioural dual-clock fifo read port
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      empty_n   <= 1'b0;
      fifo_data <= '0;
      n_pop     <= 0;
    end else begin
      f_sz = q.size();
      if (rd && f_sz > 0) begin
        fifo_data <= q.pop_front();
        f_sz      = f_sz - 1;
        n_pop     <= n_pop + 1;
      end
      empty_n <= (f_sz != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] v);
    q.push_back(v);
    expq.push_back(v);
  endtask

  task automatic sc_clear();
    sc_rd_n = 0; sc_rd_first = 0; sc_rd_last = 0;
    sc_v_n = 0;  sc_v_first = 0;  sc_v_last = 0;
  endtask

  task automatic step(input logic rdy);
    logic [BW-1:0] e;
    @(negedge clk);
    out_ready = rdy;
    #1;
    cyc++;
    if (!empty_n) chk("rd_when_empty", 32'(rd), 32'd0);
    chk("outstanding_le2", 32'((n_pop - n_deliv) <= 2), 32'd1);
`ifdef FIFO_RD_COUNT_EN
    chk("word_cnt", 32'(word_cnt), 32'(n_deliv % (1 << CW)));
`endif
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
    end
    if (rd) begin
      if (sc_rd_n == 0) sc_rd_first = cyc;
      sc_rd_last = cyc;
      sc_rd_n++;
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_word", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("data", 32'(out_data), 32'(e));
      end
      n_deliv++;
      if (sc_v_n == 0) sc_v_first = cyc;
      sc_v_last = cyc;
      sc_v_n++;
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while ((expq.size() != 0 || out_valid) && i < max) begin
      step(1'b1);
      i++;
    end
    if (i >= max) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
`ifdef FIFO_RD_COUNT_EN
    chk({tag, "_cnt"}, 32'(word_cnt), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; n_deliv = 0;
    stall_prev = 1'b0; prev_data = '0;
    out_ready = 1'b0;
    sc_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single word
    sc_clear();
    push(16'h0006);
    repeat (6) step(1'b1);
    chk("single_rd_n", 32'(sc_rd_n), 32'd1);
    chk("single_v_n", 32'(sc_v_n), 32'd1);
    chk("single_lat", 32'(sc_v_first - sc_rd_first), 32'd2);
    chk("single_idle", 32'(out_valid), 32'd0);

    // streaming
    sc_clear();
    for (int i = 1; i <= 8; i++) push(BW'(i));
    repeat (14) step(1'b1);
    chk("stream_rd_n", 32'(sc_rd_n), 32'd8);
    chk("stream_rd_run", 32'(sc_rd_last - sc_rd_first), 32'd7);
    chk("stream_v_n", 32'(sc_v_n), 32'd8);
    chk("stream_v_run", 32'(sc_v_last - sc_v_first), 32'd7);

    // backpressure
    sc_clear();
    for (int i = 1; i <= 8; i++) push(BW'(i));
    for (int i = 0; i < 30; i++) step(pat[i % 6] != 0);
    drain(40);
    chk("bp_v_n", 32'(sc_v_n), 32'd8);

    // empty boundary
    sc_clear();
    push(16'hABCD);
    repeat (6) step(1'b1);
    chk("eb_rd_n", 32'(sc_rd_n), 32'd1);
    chk("eb_v_n", 32'(sc_v_n), 32'd1);
    chk("eb_idle", 32'(out_valid), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0 && q.size() < 4)
        push(BW'($urandom));
      step(1'($urandom_range(0, 1)));
    end
    drain(60);
    chk("rand_left", 32'(expq.size()), 32'd0);

    // reset while buffer is full
    for (int i = 1; i <= 8; i++) push(BW'(16'h0100 + i));
    repeat (6) step(1'b0);
    chk("full_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    expq.delete();
    n_deliv    = 0;
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // counter wrap over 17 words
    sc_clear();
    for (int i = 0; i < 17; i++) push(BW'($urandom));
    repeat (25) step(1'b1);
    drain(40);
    chk("wrap_v_n", 32'(sc_v_n), 32'd17);
`ifdef FIFO_RD_COUNT_EN
    chk("wrap_cnt", 32'(word_cnt), 32'd1);
`else
    chk("wrap_deliv", 32'(n_deliv), 32'd17);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
